// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage ce-gated YCbCr 4:4:4 to RGB converter with saturation and an aligned sideband delay.
// Define YCBCR2RGB_STUDIO_RANGE_EN for BT.601 studio-range coefficients; otherwise full-range JFIF.
module ycbcr2rgb #(
    parameter int SYNC_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [7:0]        in_y,
    input  logic [7:0]        in_cb,
    input  logic [7:0]        in_cr,
    input  logic [SYNC_W-1:0] in_sync,
    output logic [7:0]        out_r,
    output logic [7:0]        out_g,
    output logic [7:0]        out_b,
    output logic [SYNC_W-1:0] out_sync
);
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
    localparam logic [9:0]         YOFF = 10'd16;
    localparam logic signed [20:0] KY   = 21'sd1192;
    localparam logic signed [20:0] KRV  = 21'sd1634;
    localparam logic signed [20:0] KGU  = 21'sd401;
    localparam logic signed [20:0] KGV  = 21'sd833;
    localparam logic signed [20:0] KBU  = 21'sd2065;
`else
    localparam logic [9:0]         YOFF = 10'd0;
    localparam logic signed [20:0] KY   = 21'sd1024;
    localparam logic signed [20:0] KRV  = 21'sd1436;
    localparam logic signed [20:0] KGU  = 21'sd352;
    localparam logic signed [20:0] KGV  = 21'sd731;
    localparam logic signed [20:0] KBU  = 21'sd1815;
`endif
    logic signed [9:0]        dy, dcb, dcr;
    logic signed [20:0]       p_y, p_rv, p_gu, p_gv, p_bu;
    logic signed [21:0]       s_r, s_g, s_b;
    logic signed [11:0]       q_r, q_g, q_b;
    logic [3:0][SYNC_W-1:0]   sync_d;

    function automatic logic [7:0] sat(input logic signed [11:0] v);
        return v[11] ? 8'd0 : (|v[10:8] ? 8'd255 : v[7:0]);
    endfunction

    always_comb begin
        s_r = 22'(p_y) + 22'(p_rv) + 22'sd512;
        s_g = 22'(p_y) - 22'(p_gu) - 22'(p_gv) + 22'sd512;
        s_b = 22'(p_y) + 22'(p_bu) + 22'sd512;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dy     <= '0;
            dcb    <= '0;
            dcr    <= '0;
            p_y    <= '0;
            p_rv   <= '0;
            p_gu   <= '0;
            p_gv   <= '0;
            p_bu   <= '0;
            q_r    <= '0;
            q_g    <= '0;
            q_b    <= '0;
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
            sync_d <= '0;
        end else if (ce) begin
            dy     <= 10'(in_y) - YOFF;
            dcb    <= 10'(in_cb) - 10'd128;
            dcr    <= 10'(in_cr) - 10'd128;
            p_y    <= 21'(dy) * KY;
            p_rv   <= 21'(dcr) * KRV;
            p_gu   <= 21'(dcb) * KGU;
            p_gv   <= 21'(dcr) * KGV;
            p_bu   <= 21'(dcb) * KBU;
            // top 12 bits of the rounded sum are the arithmetic >>> 10
            q_r    <= s_r[21:10];
            q_g    <= s_g[21:10];
            q_b    <= s_b[21:10];
            out_r  <= sat(q_r);
            out_g  <= sat(q_g);
            out_b  <= sat(q_b);
            sync_d <= {sync_d[2:0], in_sync};
        end
    end

    assign out_sync = sync_d[3];
endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: randomized and directed bench for ycbcr2rgb against a floating-point colour model.
// Honours YCBCR2RGB_STUDIO_RANGE_EN the same way as the design.
module tb_ycbcr2rgb;
    logic       clk = 1'b0;
    logic       rst_n, ce;
    logic [7:0] in_y, in_cb, in_cr;
    logic [2:0] in_sync;
    logic [7:0] out_r, out_g, out_b;
    logic [2:0] out_sync;
    int checks = 0;
    int errors = 0;

    typedef struct {
        real        r, g, b;
        logic [2:0] s;
    } exp_t;
    exp_t q[$];

    ycbcr2rgb #(.SYNC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_sync(in_sync),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_sync(out_sync)
    );

    always #5 clk = ~clk;

    function automatic real clampr(input real x);
        return x < 0.0 ? 0.0 : (x > 255.0 ? 255.0 : x);
    endfunction

    function automatic exp_t model(input logic [7:0] y, cb, cr, input logic [2:0] s);
        exp_t e;
        real yy, u, v;
        u = real'(int'(cb)) - 128.0;
        v = real'(int'(cr)) - 128.0;
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
        yy = 1.164 * (real'(int'(y)) - 16.0);
        e.r = clampr(yy + 1.596 * v);
        e.g = clampr(yy - 0.392 * u - 0.813 * v);
        e.b = clampr(yy + 2.017 * u);
`else
        yy = real'(int'(y));
        e.r = clampr(yy + 1.402 * v);
        e.g = clampr(yy - 0.344136 * u - 0.714136 * v);
        e.b = clampr(yy + 1.772 * u);
`endif
        e.s = s;
        return e;
    endfunction

    function automatic bit near(input logic [7:0] a, input real x);
        real d;
        d = real'(int'(a)) - x;
        return d <= 1.0 && d >= -1.0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] y, cb, cr, input logic [2:0] s);
        ce = 1'b1; in_y = y; in_cb = cb; in_cr = cr; in_sync = s;
        repeat (4) step();
        q.delete();
        repeat (3) q.push_back(model(y, cb, cr, s));
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; ce = 1'b1;
        in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom); in_sync = 3'b111;
        repeat (3) step();
        checks++;
        if ({out_r, out_g, out_b, out_sync} !== 27'd0) begin
            errors++;
            $display("FAIL reset_hold got r=%0d g=%0d b=%0d s=%b want all 0", out_r, out_g, out_b, out_sync);
        end
        #2 rst_n = 1'b1;
        in_y = 8'd128; in_cb = 8'd128; in_cr = 8'd128; in_sync = 3'b100;
        e = model(in_y, in_cb, in_cr, in_sync);
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4 && {out_r, out_g, out_b, out_sync} !== 27'd0) begin
                errors++;
                $display("FAIL flush_%0d got r=%0d g=%0d b=%0d s=%b want all 0", i, out_r, out_g, out_b, out_sync);
            end
            if (i == 4 && (out_sync !== e.s || !near(out_r, e.r) || !near(out_g, e.g) || !near(out_b, e.b))) begin
                errors++;
                $display("FAIL first_pixel got %0d/%0d/%0d s=%b want ~%0.1f/%0.1f/%0.1f s=%b",
                         out_r, out_g, out_b, out_sync, e.r, e.g, e.b, e.s);
            end
        end
    endtask

    task automatic test_vector(input string name, input logic [7:0] y, cb, cr, input logic [2:0] s,
                               input logic [7:0] er, eg, eb);
        ce = 1'b1; in_y = y; in_cb = cb; in_cr = cr; in_sync = s;
        repeat (4) step();
        checks++;
        if ({out_r, out_g, out_b, out_sync} !== {er, eg, eb, s}) begin
            errors++;
            $display("FAIL %s got %0d/%0d/%0d s=%b want %0d/%0d/%0d s=%b",
                     name, out_r, out_g, out_b, out_sync, er, eg, eb, s);
        end
    endtask

    task automatic test_ce_toggle();
        exp_t e;
        logic [26:0] prev;
        bit ce_v;
        int k = 0;
        fill(8'd10, 8'd20, 8'd30, 3'b000);
        for (int cyc = 0; k < 11; cyc++) begin
            ce_v = (cyc % 3 == 0);
            ce = ce_v;
            if (ce_v) begin
                in_y = 8'(k * 31 + 5); in_cb = 8'(255 - k * 23); in_cr = 8'(k * 17 + 40); in_sync = 3'(k);
                q.push_back(model(in_y, in_cb, in_cr, in_sync));
                k++;
            end else begin
                in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom); in_sync = 3'($urandom);
            end
            prev = {out_r, out_g, out_b, out_sync};
            step();
            checks++;
            if (ce_v) begin
                e = q.pop_front();
                if (out_sync !== e.s || !near(out_r, e.r) || !near(out_g, e.g) || !near(out_b, e.b)) begin
                    errors++;
                    $display("FAIL ce_toggle_pix cyc=%0d got %0d/%0d/%0d s=%b want ~%0.1f/%0.1f/%0.1f s=%b",
                             cyc, out_r, out_g, out_b, out_sync, e.r, e.g, e.b, e.s);
                end
            end else if ({out_r, out_g, out_b, out_sync} !== prev) begin
                errors++;
                $display("FAIL ce_toggle_hold cyc=%0d got %h want %h", cyc, {out_r, out_g, out_b, out_sync}, prev);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        ce = 1'b1;
        repeat (6) begin
            in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom); in_sync = 3'b111;
            step();
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_r, out_g, out_b, out_sync} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset_now got r=%0d g=%0d b=%0d s=%b want all 0", out_r, out_g, out_b, out_sync);
        end
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        in_y = 8'($urandom_range(60, 200)); in_cb = 8'($urandom); in_cr = 8'($urandom); in_sync = 3'b101;
        e = model(in_y, in_cb, in_cr, in_sync);
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4 && {out_r, out_g, out_b, out_sync} !== 27'd0) begin
                errors++;
                $display("FAIL async_flush_%0d got r=%0d g=%0d b=%0d s=%b want all 0", i, out_r, out_g, out_b, out_sync);
            end
            if (i == 4 && (out_sync !== e.s || !near(out_r, e.r) || !near(out_g, e.g) || !near(out_b, e.b))) begin
                errors++;
                $display("FAIL async_new_data got %0d/%0d/%0d s=%b want ~%0.1f/%0.1f/%0.1f s=%b",
                         out_r, out_g, out_b, out_sync, e.r, e.g, e.b, e.s);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [26:0] prev;
        bit ce_v;
        int n = 0;
        fill(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
        for (int cyc = 0; n < 10000; cyc++) begin
            ce_v = ($urandom_range(0, 3) != 0);
            ce = ce_v;
            in_y = 8'($urandom); in_cb = 8'($urandom); in_cr = 8'($urandom); in_sync = 3'($urandom);
            if (ce_v) begin
                q.push_back(model(in_y, in_cb, in_cr, in_sync));
                n++;
            end
            prev = {out_r, out_g, out_b, out_sync};
            step();
            checks++;
            if (ce_v) begin
                e = q.pop_front();
                if (out_sync !== e.s || !near(out_r, e.r) || !near(out_g, e.g) || !near(out_b, e.b)) begin
                    errors++;
                    $display("FAIL random_pix cyc=%0d got %0d/%0d/%0d s=%b want ~%0.1f/%0.1f/%0.1f s=%b",
                             cyc, out_r, out_g, out_b, out_sync, e.r, e.g, e.b, e.s);
                end
            end else if ({out_r, out_g, out_b, out_sync} !== prev) begin
                errors++;
                $display("FAIL random_hold cyc=%0d got %h want %h", cyc, {out_r, out_g, out_b, out_sync}, prev);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0;
        in_y = '0; in_cb = '0; in_cr = '0; in_sync = '0;
        test_reset();
`ifdef YCBCR2RGB_STUDIO_RANGE_EN
        test_vector("white",   8'd235, 8'd128, 8'd128, 3'b100, 8'd255, 8'd255, 8'd255);
        test_vector("black",   8'd16,  8'd128, 8'd128, 3'b010, 8'd0,   8'd0,   8'd0);
        test_vector("below16", 8'd0,   8'd128, 8'd128, 3'b001, 8'd0,   8'd0,   8'd0);
`else
        test_vector("gray",    8'd128, 8'd128, 8'd128, 3'b100, 8'd128, 8'd164 - 8'd36, 8'd128);
        test_vector("r_high",  8'd255, 8'd128, 8'd255, 3'b010, 8'd255, 8'd164, 8'd255);
        test_vector("rb_low",  8'd0,   8'd0,   8'd0,   3'b001, 8'd0,   8'd135, 8'd0);
`endif
        test_ce_toggle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
